// File: rtl/rle_scan_engine.sv
// ----------------------------------------------------------------------------
// rle_scan_engine
//
// Reads a length-prefixed element list from a synchronous-read memory and
// streams it downstream as beats. The word at base holds N, the element count.
// The elements follow at base+1 .. base+N, and the address wraps modulo
// 2^ADDR_W.
//   mode 0 : every element leaves as its own beat with repeats = 1.
//   mode 1 : runs of equal adjacent elements are merged into one beat
//            (value, repeats). A run that reaches 2^CNT_W-1 is closed, and
//            the next equal element opens a new run.
//
// Ports
//   i_clk, i_resetn      clock; synchronous active-low reset
//   i_start              one-cycle start request (sampled in IDLE only)
//   i_mode, i_base_addr  job configuration, latched when start is accepted
//   o_mem_addr           memory read address
//   i_mem_rdata          read data, one cycle after o_mem_addr
//   o_valid, i_ready     beat handshake; transfer on o_valid && i_ready
//   o_data, o_repeats    beat payload (run value, run length)
//   o_busy               job in progress
//   o_done               one-cycle completion pulse
// ----------------------------------------------------------------------------
module rle_scan_engine #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_resetn,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_repeats,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_RD,
        LEN_CAP,
        ELEM_RD,
        ELEM_CAP,
        EMIT,
        DONE
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e            state_q,     state_d;
    logic              mode_q,      mode_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;      // next address to present
    logic [DATA_W-1:0] rem_q,       rem_d;       // elements still to capture
    logic [DATA_W-1:0] run_val_q,   run_val_d;   // open run (mode 1)
    logic [CNT_W-1:0]  run_cnt_q,   run_cnt_d;   // 0 = no open run
    logic [DATA_W-1:0] beat_data_q, beat_data_d; // payload held on the port
    logic [CNT_W-1:0]  beat_cnt_q,  beat_cnt_d;

    logic              extend;
    logic [DATA_W-1:0] rem_dec;

    // The incoming element joins the open run only if the run is not already
    // saturated. A saturated run is closed when the next element arrives.
    assign extend  = (run_cnt_q != '0) && (i_mem_rdata == run_val_q) &&
                     (run_cnt_q != CNT_MAX);
    assign rem_dec = rem_q - 1'b1;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            addr_q      <= '0;
            rem_q       <= '0;
            run_val_q   <= '0;
            run_cnt_q   <= '0;
            beat_data_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            run_val_q   <= run_val_d;
            run_cnt_q   <= run_cnt_d;
            beat_data_q <= beat_data_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    //
    // The address register always points one element ahead of the capture.
    // While a beat waits in EMIT, the next element's address is already on
    // o_mem_addr but nothing is consumed. On the handshake, the FSM moves
    // straight to ELEM_CAP, so mode 0 runs one element every two cycles.
    // ------------------------------------------------------------------------
    // NOTE: every variable gets its default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        run_val_d   = run_val_q;
        run_cnt_d   = run_cnt_q;
        beat_data_d = beat_data_q;
        beat_cnt_d  = beat_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    mode_d  = i_mode;
                    addr_d  = i_base_addr;
                    state_d = LEN_RD;
                end
            end

            LEN_RD: state_d = LEN_CAP;

            LEN_CAP: begin
                rem_d     = i_mem_rdata;
                run_cnt_d = '0;
                if (i_mem_rdata == '0) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ELEM_RD;
                end
            end

            ELEM_RD: state_d = ELEM_CAP;

            ELEM_CAP: begin
                rem_d  = rem_dec;
                addr_d = addr_q + 1'b1;
                if (!mode_q) begin
                    beat_data_d = i_mem_rdata;
                    beat_cnt_d  = CNT_ONE;
                    state_d     = EMIT;
                end else if (extend || (run_cnt_q == '0)) begin
                    // Grow or open the run. If this was the last element,
                    // emit the run at once instead of leaving it open.
                    if (rem_dec == '0) begin
                        beat_data_d = i_mem_rdata;
                        beat_cnt_d  = extend ? run_cnt_q + 1'b1 : CNT_ONE;
                        run_cnt_d   = '0;
                        state_d     = EMIT;
                    end else begin
                        run_val_d = i_mem_rdata;
                        run_cnt_d = extend ? run_cnt_q + 1'b1 : CNT_ONE;
                        state_d   = ELEM_RD;
                    end
                end else begin
                    // Value change or saturation: close the old run and open
                    // a new run with this element. If this was the last
                    // element, EMIT flushes the new run after the handshake.
                    beat_data_d = run_val_q;
                    beat_cnt_d  = run_cnt_q;
                    run_val_d   = i_mem_rdata;
                    run_cnt_d   = CNT_ONE;
                    state_d     = EMIT;
                end
            end

            EMIT: begin
                if (i_ready) begin
                    if (rem_q != '0) begin
                        state_d = ELEM_CAP;
                    end else if (run_cnt_q != '0) begin
                        beat_data_d = run_val_q;
                        beat_cnt_d  = run_cnt_q;
                        run_cnt_d   = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_mem_addr = addr_q;
    assign o_valid    = (state_q == EMIT);
    assign o_data     = beat_data_q;
    assign o_repeats  = beat_cnt_q;
    assign o_done     = (state_q == DONE);
    assign o_busy     = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_rle_scan_engine.sv
// ----------------------------------------------------------------------------
// tb_rle_scan_engine
//
// Directed bench for rle_scan_engine. It has two instances: the default
// build (CNT_W = 8) and a CNT_W = 4 build for the saturation-split job. Each
// instance reads one shared memory array through its own registered read
// port. A negedge monitor collects transferred beats, counts o_done cycles,
// and checks that the payload holds while the consumer stalls.
// ----------------------------------------------------------------------------
module tb_rle_scan_engine;

    logic       clk;
    logic       resetn;
    logic       start8, start4;
    logic       mode;
    logic [7:0] base_addr;
    logic       ready;

    logic [7:0] addr8, rdata8, data8;
    logic [7:0] rep8;
    logic       valid8, busy8, done8;

    logic [7:0] addr4, rdata4, data4;
    logic [3:0] rep4;
    logic       valid4, busy4, done4;

    logic [7:0] mem [256];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int zero_rep = 0;
    int q_data[$];
    int q_rep[$];

    bit         stall_prev = 1'b0;
    logic [7:0] prev_data;
    logic [7:0] prev_rep;

    rle_scan_engine #(.DATA_W(8), .ADDR_W(8), .CNT_W(8)) dut8 (
        .i_clk      (clk),
        .i_resetn   (resetn),
        .i_start    (start8),
        .i_mode     (mode),
        .i_base_addr(base_addr),
        .o_mem_addr (addr8),
        .i_mem_rdata(rdata8),
        .o_valid    (valid8),
        .i_ready    (ready),
        .o_data     (data8),
        .o_repeats  (rep8),
        .o_busy     (busy8),
        .o_done     (done8)
    );

    rle_scan_engine #(.DATA_W(8), .ADDR_W(8), .CNT_W(4)) dut4 (
        .i_clk      (clk),
        .i_resetn   (resetn),
        .i_start    (start4),
        .i_mode     (mode),
        .i_base_addr(base_addr),
        .o_mem_addr (addr4),
        .i_mem_rdata(rdata4),
        .o_valid    (valid4),
        .i_ready    (ready),
        .o_data     (data4),
        .o_repeats  (rep4),
        .o_busy     (busy4),
        .o_done     (done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: data appears one cycle after the address.
    always @(posedge clk) begin
        rdata8 <= mem[addr8];
        rdata4 <= mem[addr4];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Beat collector and stall-stability monitor
    always @(negedge clk) begin
        if (resetn) begin
            if (stall_prev) begin
                check("stall_valid", {31'd0, valid8}, 32'd1);
                check("stall_data", {24'd0, data8}, {24'd0, prev_data});
                check("stall_rep", {24'd0, rep8}, {24'd0, prev_rep});
            end
            if (done8 || done4) done_cnt++;
            if (valid8 && rep8 == 8'd0) zero_rep++;
            if (valid4 && rep4 == 4'd0) zero_rep++;
            if (valid8 && ready) begin
                q_data.push_back(int'(data8));
                q_rep.push_back(int'(rep8));
            end
            if (valid4 && ready) begin
                q_data.push_back(int'(data4));
                q_rep.push_back(int'(rep4));
            end
        end
        stall_prev = resetn && valid8 && !ready;
        prev_data  = data8;
        prev_rep   = rep8;
    end

    function automatic int qd(input int i);
        return (i < q_data.size()) ? q_data[i] : -1;
    endfunction

    function automatic int qr(input int i);
        return (i < q_rep.size()) ? q_rep[i] : -1;
    endfunction

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    // Starts a job on one instance, then waits a bounded number of cycles
    // for o_done and four more cycles to catch stray beats or pulses.
    // With toggle set, i_ready flips every cycle. With poke set, a second
    // start request with different configuration arrives mid-job.
    task automatic run_job(input bit use4, input bit md, input logic [7:0] base,
                           input bit toggle, input bit poke, input int budget,
                           output int cycles);
        bit seen;
        seen = 1'b0;
        q_data.delete();
        q_rep.delete();
        done_cnt  = 0;
        mode      = md;
        base_addr = base;
        ready     = !toggle;
        if (use4) start4 = 1'b1;
        else      start8 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        start8 = 1'b0;
        cycles = 1;
        check("busy_after_start", {31'd0, use4 ? busy4 : busy8}, 32'd1);
        while (!seen && cycles < budget) begin
            if (toggle) ready = ~ready;
            if (poke && cycles == 8) begin
                start8    = 1'b1;
                mode      = ~md;
                base_addr = 8'h40;
            end else begin
                start8 = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
            seen = use4 ? done4 : done8;
        end
        start8 = 1'b0;
        ready  = 1'b1;
        check("done_seen", {31'd0, seen}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("busy_after_done", {31'd0, use4 ? busy4 : busy8}, 32'd0);
    endtask

    initial begin
        int cyc;
        int n;
        resetn    = 1'b0;
        start8    = 1'b1;   // held high through reset: must be ignored
        start4    = 1'b1;
        mode      = 1'b0;
        base_addr = 8'd0;
        ready     = 1'b1;
        fill_mem(8'hEE);

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, valid8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_data", {24'd0, data8}, 32'd0);
        check("rst_rep", {24'd0, rep8}, 32'd0);
        check("rst_addr", {24'd0, addr8}, 32'd0);
        resetn = 1'b1;
        start8 = 1'b0;
        start4 = 1'b0;
        @(posedge clk); #1;
        check("start_in_reset_ignored", {31'd0, busy8 | busy4}, 32'd0);

        // ---------------- mode 0, 120 elements ----------------
        mem[0] = 8'd120;
        for (int k = 1; k <= 120; k++) mem[k] = 8'(k);
        run_job(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 400, cyc);
        check("m0_count", q_data.size(), 120);
        for (int i = 0; i < 120; i++) begin
            check("m0_data", qd(i), i + 1);
            check("m0_rep", qr(i), 1);
        end
        check("m0_done_once", done_cnt, 1);
        check("m0_throughput", {31'd0, cyc <= 250}, 32'd1);

        // ---------------- mode 1, {4,5,5,5,7} ----------------
        fill_mem(8'hEE);
        mem[0] = 8'd4; mem[1] = 8'd5; mem[2] = 8'd5; mem[3] = 8'd5; mem[4] = 8'd7;
        run_job(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 400, cyc);
        check("m1_count", q_data.size(), 2);
        check("m1_b0_data", qd(0), 5);
        check("m1_b0_rep", qr(0), 3);
        check("m1_b1_data", qd(1), 7);
        check("m1_b1_rep", qr(1), 1);
        check("m1_done_once", done_cnt, 1);

        // ---------------- same data, ready toggling, ignored mid-job start ----
        run_job(1'b0, 1'b1, 8'd0, 1'b1, 1'b1, 400, cyc);
        check("tog_count", q_data.size(), 2);
        check("tog_b0_data", qd(0), 5);
        check("tog_b0_rep", qr(0), 3);
        check("tog_b1_data", qd(1), 7);
        check("tog_b1_rep", qr(1), 1);
        check("tog_done_once", done_cnt, 1);

        // ---------------- mode 1, single run flushed at end ----------------
        fill_mem(8'hEE);
        mem[0] = 8'd3; mem[1] = 8'd6; mem[2] = 8'd6; mem[3] = 8'd6;
        run_job(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 400, cyc);
        check("flush_count", q_data.size(), 1);
        check("flush_data", qd(0), 6);
        check("flush_rep", qr(0), 3);

        // ---------------- CNT_W = 4, twenty 9s: saturation split ----------
        fill_mem(8'hEE);
        mem[0] = 8'd20;
        for (int k = 1; k <= 20; k++) mem[k] = 8'd9;
        run_job(1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 400, cyc);
        check("sat_count", q_data.size(), 2);
        check("sat_b0_data", qd(0), 9);
        check("sat_b0_rep", qr(0), 15);
        check("sat_b1_data", qd(1), 9);
        check("sat_b1_rep", qr(1), 5);
        check("sat_done_once", done_cnt, 1);

        // ---------------- empty list ----------------
        fill_mem(8'hEE);
        mem[0] = 8'd0;
        run_job(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 400, cyc);
        check("empty_no_beats", q_data.size(), 0);
        check("empty_done_once", done_cnt, 1);

        // ---------------- address wrap: base 254, N 3 ----------------
        fill_mem(8'hEE);
        mem[254] = 8'd3; mem[255] = 8'hA1; mem[0] = 8'hA2; mem[1] = 8'hA3;
        run_job(1'b0, 1'b0, 8'd254, 1'b0, 1'b0, 400, cyc);
        check("wrap_count", q_data.size(), 3);
        check("wrap_b0", qd(0), 32'hA1);
        check("wrap_b1", qd(1), 32'hA2);
        check("wrap_b2", qd(2), 32'hA3);

        // ---------------- reset during third beat ----------------
        fill_mem(8'hEE);
        mem[0] = 8'd120;
        for (int k = 1; k <= 120; k++) mem[k] = 8'(k);
        q_data.delete();
        q_rep.delete();
        done_cnt  = 0;
        mode      = 1'b0;
        base_addr = 8'd0;
        ready     = 1'b1;
        start8    = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        n = 0;
        while (!(valid8 && q_data.size() == 2) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_third_beat_reached", {31'd0, n < 100}, 32'd1);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("abort_valid", {31'd0, valid8}, 32'd0);
        check("abort_done", {31'd0, done8}, 32'd0);
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_data", {24'd0, data8}, 32'd0);
        check("abort_rep", {24'd0, rep8}, 32'd0);
        check("abort_addr", {24'd0, addr8}, 32'd0);
        resetn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_more_beats", q_data.size(), 2);
        check("abort_no_done", done_cnt, 0);

        run_job(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 400, cyc);
        check("restart_count", q_data.size(), 120);
        check("restart_first", qd(0), 1);
        check("restart_last", qd(119), 120);
        check("restart_done_once", done_cnt, 1);

        check("never_zero_repeats", zero_rep, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
